// File: rtl/rtype_pkg.sv
// rtype_pkg: RV32I R-type opcode/funct constants, op index enum and the word encoder.
package rtype_pkg;
   localparam logic [6:0] OPC_RTYPE   = 7'b0110011;
   localparam logic [6:0] F7_BASE     = 7'b0000000;
   localparam logic [6:0] F7_ALT      = 7'b0100000;
   localparam logic [2:0] F3_ADD_SUB  = 3'b000;
   localparam logic [2:0] F3_SLL      = 3'b001;
   localparam logic [2:0] F3_SLT      = 3'b010;
   localparam logic [2:0] F3_SLTU     = 3'b011;
   localparam logic [2:0] F3_XOR      = 3'b100;
   localparam logic [2:0] F3_SRL_SRA  = 3'b101;
   localparam logic [2:0] F3_OR       = 3'b110;
   localparam logic [2:0] F3_AND      = 3'b111;

   typedef enum logic [3:0] {ADD, SUB, AND, OR, SLL, SLT, SLTU, XOR, SRL, SRA} op_idx_e;

   function automatic logic [31:0] encode_rtype(op_idx_e op, logic [4:0] rs1, logic [4:0] rs2,
                                                logic [4:0] rd);
      logic [2:0] f3;
      logic [6:0] f7;
      case (op)
         SLL:      f3 = F3_SLL;
         SLT:      f3 = F3_SLT;
         SLTU:     f3 = F3_SLTU;
         XOR:      f3 = F3_XOR;
         SRL, SRA: f3 = F3_SRL_SRA;
         OR:       f3 = F3_OR;
         AND:      f3 = F3_AND;
         default:  f3 = F3_ADD_SUB;
      endcase
      f7 = (op == SUB || op == SRA) ? F7_ALT : F7_BASE;
      return {f7, rs2, rs1, f3, rd, OPC_RTYPE};
   endfunction
endpackage

// File: rtl/rtype_encoder_fifo.sv
// rtype_fifo: synchronous FIFO with occupancy count; output holds the last popped word when empty.
module rtype_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 32,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [W-1:0]     data_i,
   input  logic             pop_i,
   output logic [W-1:0]     data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0]     mem_q [DEPTH];
   logic [AW-1:0]    wr_q, rd_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [W-1:0]     last_q;
   logic             do_push, do_pop;

   assign full_o  = cnt_q == CNT_W'(DEPTH);
   assign empty_o = cnt_q == '0;
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign cnt_d   = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
   assign count_o = cnt_q;
   // Head slot may hold stale data once drained, so show the last popped word instead.
   assign data_o  = empty_o ? last_q : mem_q[rd_q];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_q   <= '0;
         rd_q   <= '0;
         cnt_q  <= '0;
         last_q <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_q] <= data_i;
            wr_q        <= wr_q + 1'b1;
         end
         if (do_pop) begin
            last_q <= mem_q[rd_q];
            rd_q   <= rd_q + 1'b1;
         end
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/rtype_encoder.sv
// rtype_encoder: one-hot op select + registers -> R-type word, buffered through rtype_fifo.
// RTYPE_ILLEGAL_CHECK_EN: reject non-one-hot op_sel with a one-cycle err pulse instead of priority decode.
module rtype_encoder
   import rtype_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clock_i,
   input  logic             reset_ni,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [9:0]       op_sel_i,
   input  logic [4:0]       rs1_i,
   input  logic [4:0]       rs2_i,
   input  logic [4:0]       rd_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [31:0]      out_instr_o,
   output logic [CNT_W-1:0] count_o,
   output logic             err_o
);
   op_idx_e op;
   logic    full, empty, legal, accept;

   always_comb begin
      op = ADD;
      for (int i = 9; i >= 0; i--) if (op_sel_i[i]) op = op_idx_e'(4'(i));
   end

   assign in_ready_o  = !full;
   assign out_valid_o = !empty;
   assign accept      = in_valid_i && in_ready_o;

`ifdef RTYPE_ILLEGAL_CHECK_EN
   logic err_q;
   assign legal = $onehot(op_sel_i);
   assign err_o = err_q;
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) err_q <= 1'b0;
      else           err_q <= accept && !legal;
   end
`else
   assign legal = 1'b1;
   assign err_o = 1'b0;
`endif

   rtype_fifo #(.DEPTH(DEPTH), .W(32), .CNT_W(CNT_W)) u_fifo (
      .clk_i   (clock_i),
      .rst_ni  (reset_ni),
      .push_i  (accept && legal),
      .data_i  (encode_rtype(op, rs1_i, rs2_i, rd_i)),
      .pop_i   (out_ready_i),
      .data_o  (out_instr_o),
      .full_o  (full),
      .empty_o (empty),
      .count_o (count_o)
   );
endmodule

// File: tb/tb_rtype_encoder.sv
// tb_rtype_encoder: table-driven vectors plus handshake corner sequences, scoreboard-checked output stream.
module tb_rtype_encoder;
   localparam int DEPTH = 4;
   localparam int NV    = 12;
   typedef struct {
      logic [9:0]  op;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] exp;
   } vec_t;

   logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [9:0]  op_sel = '0;
   logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
   logic        in_ready, out_valid, err;
   logic [31:0] out_instr;
   logic [2:0]  count;
   int          vectors = 0, miscompares = 0;
   logic [31:0] sb[$];
   vec_t        tv[NV];

   rtype_encoder #(.DEPTH(DEPTH), .CNT_W(3)) dut (
      .clock_i(clk), .reset_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .op_sel_i(op_sel), .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd), .out_valid_o(out_valid),
      .out_ready_i(out_ready), .out_instr_o(out_instr), .count_o(count), .err_o(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL stream: unexpected word %h, scoreboard empty", out_instr);
         end else chk("stream", out_instr, sb.pop_front());
      end
   end

   task automatic set_in(input vec_t v);
      op_sel = v.op; rs1 = v.rs1; rs2 = v.rs2; rd = v.rd;
   endtask

   task automatic drive(input vec_t v);
      int n = 0;
      @(posedge clk); #1;
      set_in(v);
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 20) begin @(negedge clk); n++; end
      if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
      else sb.push_back(v.exp);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (sb.size() != 0 && n < 40) begin @(negedge clk); n++; end
      chk(name, 32'(sb.size()), 32'd0);
   endtask

   initial begin
      tv[0]  = '{10'b0000000001, 5'd7,  5'd4,  5'd9,  32'h004384B3};
      tv[1]  = '{10'b0000000010, 5'd5,  5'd13, 5'd19, 32'h40D289B3};
      tv[2]  = '{10'b1000000000, 5'd7,  5'd4,  5'd9,  32'h4043D4B3};
      tv[3]  = '{10'b0000000100, 5'd7,  5'd4,  5'd9,  32'h0043F4B3};
      tv[4]  = '{10'b0000001000, 5'd1,  5'd2,  5'd3,  32'h0020E1B3};
      tv[5]  = '{10'b0000010000, 5'd31, 5'd31, 5'd31, 32'h01FF9FB3};
      tv[6]  = '{10'b0000100000, 5'd0,  5'd0,  5'd0,  32'h00002033};
      tv[7]  = '{10'b0001000000, 5'd2,  5'd3,  5'd1,  32'h003130B3};
      tv[8]  = '{10'b0010000000, 5'd10, 5'd11, 5'd12, 32'h00B54633};
      tv[9]  = '{10'b0100000000, 5'd1,  5'd1,  5'd1,  32'h0010D0B3};
      tv[10] = '{10'b0000000001, 5'd0,  5'd0,  5'd0,  32'h00000033};
      tv[11] = '{10'b0000000001, 5'd31, 5'd0,  5'd0,  32'h000F8033};

      #12;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_out_instr", out_instr, 32'h0);
      @(negedge clk) rst_n = 1'b1;

      // latency: no bypass, word visible one cycle after acceptance
      out_ready = 1'b1;
      @(posedge clk); #1;
      set_in(tv[0]);
      in_valid = 1'b1;
      @(negedge clk);
      chk("no_bypass_valid", 32'(out_valid), 32'd0);
      sb.push_back(tv[0].exp);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("latency_valid", 32'(out_valid), 32'd1);
      chk("latency_instr", out_instr, 32'h004384B3);
      drain("drain_latency");

      for (int i = 0; i < NV; i++) drive(tv[i]);
      drain("drain_table");

      // fill to full, reject extra push, reject push-on-pop when full
      out_ready = 1'b0;
      for (int i = 1; i <= DEPTH; i++) drive(tv[i]);
      chk("full_count", 32'(count), 32'(DEPTH));
      chk("full_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      set_in(tv[8]);
      in_valid = 1'b1;
      @(posedge clk); #1;
      chk("extra_push_count", 32'(count), 32'(DEPTH));
      chk("extra_out_hold", out_instr, tv[1].exp);
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("full_pop_count", 32'(count), 32'(DEPTH - 1));
      chk("full_pop_in_ready", 32'(in_ready), 32'd1);
      for (int k = DEPTH - 2; k >= 0; k--) begin
         @(posedge clk); #1;
         chk("drain_count", 32'(count), 32'(k));
      end
      chk("empty_valid", 32'(out_valid), 32'd0);
      chk("empty_hold", out_instr, tv[DEPTH].exp);
      @(posedge clk); #1;
      chk("empty_pop_count", 32'(count), 32'd0);
      chk("empty_sb", 32'(sb.size()), 32'd0);

      // half full, concurrent push and pop with pointer wrap
      out_ready = 1'b0;
      drive(tv[5]);
      drive(tv[6]);
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 8; i++) begin
         set_in(tv[(i + 7) % NV]);
         @(negedge clk);
         if (in_ready) sb.push_back(tv[(i + 7) % NV].exp);
         else chk("pp_in_ready", 32'(in_ready), 32'd1);
         chk("pp_count", 32'(count), 32'd2);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      drain("drain_pp");
      chk("pp_final_count", 32'(count), 32'd0);

      // op_sel with two bits set
      out_ready = 1'b0;
      @(posedge clk); #1;
      op_sel = 10'b0000000101; rs1 = 5'd1; rs2 = 5'd2; rd = 5'd3;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
`ifdef RTYPE_ILLEGAL_CHECK_EN
      chk("illegal_err", 32'(err), 32'd1);
      chk("illegal_count", 32'(count), 32'd0);
      @(posedge clk); #1;
      chk("illegal_err_pulse", 32'(err), 32'd0);
`else
      chk("multi_err", 32'(err), 32'd0);
      chk("multi_count", 32'(count), 32'd1);
      chk("multi_instr", out_instr, 32'h002081B3);
      sb.push_back(32'h002081B3);
      out_ready = 1'b1;
      drain("drain_multi");
`endif

      // asynchronous reset mid-stream
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) drive(tv[i]);
      chk("pre_rst_count", 32'(count), 32'd3);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_count", 32'(count), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      chk("mid_rst_err", 32'(err), 32'd0);
      sb.delete();
      @(negedge clk) rst_n = 1'b1;
      out_ready = 1'b1;
      drive(tv[3]);
      drain("drain_post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
